riscv_clk_ctrl: RTL and testbench
=================================

Name: riscv_clk_ctrl

Overview:
Run-control and rate scheduler for the core clock-enable. It generates a one-cycle clock-enable pulse (ce_o) every DIV system cycles. It accepts run, halt and single-step commands through a valid/ready handshake, and accepts divisor reconfiguration through a separate valid/ready handshake. A new divisor takes effect only at a period boundary, so no short or long enable period is ever produced. It sits between the debug/boot control logic and the core pipeline stall/enable inputs.

Parameters:
CNT_W, 8, width of the divisor and of the internal period counter.
DIV_RST, 3, divisor loaded at reset; must be < 2**CNT_W.

Ports:
clk_i  in  1  system clock.
x_reset  in  1  reset, asynchronous, active-low.
cmd_valid_i  in  1  command request.
cmd_i  in  2  command: 00 NOP, 01 RUN, 10 HALT, 11 STEP.
cmd_ready_o  out  1  command can be accepted.
cfg_valid_i  in  1  divisor update request.
cfg_div_i  in  CNT_W  new divisor; 0 is treated as 1.
cfg_ready_o  out  1  divisor update can be accepted.
ce_o  out  1  core clock-enable pulse; one cycle wide.
step_done_o  out  1  one-cycle pulse, coincident with the ce_o of a STEP.
state_o  out  2  current state: 00 HALT, 01 RUN, 10 STEP.
div_o  out  CNT_W  divisor currently in effect (after the 0-to-1 mapping).

Behaviour:
- Clock and reset: single clock, clk_i. Reset x_reset is asynchronous and active-low.
- Reset values (all state is registered):
  - state HALT, counter 0, div_o = DIV_RST, no pending config.
  - ce_o = 0, step_done_o = 0, cmd_ready_o = 1, cfg_ready_o = 1.
- Handshakes:
  - A command is accepted on an edge where cmd_valid_i & cmd_ready_o.
  - A config is accepted on an edge where cfg_valid_i & cfg_ready_o.
  - Both may be accepted on the same edge.
- Period counter:
  - Held at 0 in HALT.
  - In RUN/STEP it increments each cycle. When it equals div_o-1 (the boundary), it returns to 0 and ce_o is 1 for the following cycle only.
  - On acceptance of RUN or STEP from HALT, the counter starts at 0. The first ce_o is therefore high exactly div_o cycles after the accept edge.
  - With div_o = 1, ce_o is high every cycle starting 1 cycle after the accept edge.
- States and transitions:
  - HALT --RUN--> RUN.
  - HALT --STEP--> STEP.
  - HALT --HALT/NOP--> HALT (accepted, no effect).
  - RUN --HALT--> HALT. Takes effect on the accept edge: counter cleared, and no ce_o in the following cycle, even if that edge was a boundary.
  - RUN --RUN/STEP/NOP--> RUN (accepted, no effect).
  - STEP: at the boundary, ce_o=1 and step_done_o=1 for one cycle, and the state returns to HALT.
  - cmd_ready_o is 0 throughout STEP. Commands are never dropped, only back-pressured.
- Configuration:
  - In HALT (cfg_ready_o=1), an accepted divisor is written to div_o on the accept edge. cfg_ready_o stays 1.
  - If RUN or STEP is accepted on the same edge, the new divisor governs the first period.
  - In RUN/STEP, an accepted divisor is held pending and cfg_ready_o drops to 0 on the accept edge.
  - A pending divisor loads into div_o on the next boundary edge; cfg_ready_o returns to 1 after that edge.
  - The period ending at that boundary uses the old divisor; the next period uses the new one.
  - If HALT is accepted while a divisor is pending, the pending value loads on the HALT edge and cfg_ready_o returns to 1.
  - A config accepted on a boundary edge in RUN is pending and applies at the next boundary, not the current one.
- Width rules:
  - cfg_div_i = 0 is stored as 1.
  - The counter never exceeds div_o-1. No wrap past 2**CNT_W-1 is possible.
- Reset mid-operation: all outputs return to their reset values immediately (asynchronously). Any pending config or step in progress is discarded.

Test Plan:
1. Reset, then RUN accepted at cycle 0 with DIV_RST=3 -> ce_o high at cycles 3, 6, 9, …; each pulse is 1 cycle; state_o=01.
2. HALT, cfg_div_i=5, STEP accepted on the same edge -> div_o=5, ce_o and step_done_o high together 5 cycles later. State returns to 00. cmd_ready_o is 0 during STEP and back to 1 after the pulse.
3. RUN with div 4; cfg_div_i=2 accepted 1 cycle after a ce_o -> cfg_ready_o low. The next ce_o comes 4 cycles after the previous one, subsequent pulses every 2 cycles, and cfg_ready_o returns to 1.
4. RUN with div 3; HALT issued on a boundary edge -> no ce_o after that edge, counter 0, state_o=00. A following RUN restarts with the first ce_o 3 cycles later.
5. cfg_div_i=0 in HALT, then RUN -> div_o=1, ce_o continuously high from 1 cycle after the accept edge.
6. Assert x_reset low asynchronously during STEP with a divisor pending -> ce_o=0, step_done_o=0, state_o=00, div_o=DIV_RST, both ready outputs =1, with no clock edge required.

Source files
------------

// File: rtl/riscv_clk_ctrl.sv
// Run-control and rate scheduler for the core clock-enable: emits one ce_o pulse per
// divisor period and handles RUN/HALT/STEP commands and boundary-aligned divisor updates.
module riscv_clk_ctrl #(
    parameter int CNT_W   = 8,
    parameter int DIV_RST = 3
) (
    input  logic             clk_i,
    input  logic             x_reset,
    input  logic             cmd_valid_i,
    input  logic [1:0]       cmd_i,
    output logic             cmd_ready_o,
    input  logic             cfg_valid_i,
    input  logic [CNT_W-1:0] cfg_div_i,
    output logic             cfg_ready_o,
    output logic             ce_o,
    output logic             step_done_o,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] div_o
);

    typedef enum logic [1:0] {
        ST_HALT = 2'b00,
        ST_RUN  = 2'b01,
        ST_STEP = 2'b10
    } state_t;

    localparam logic [1:0]       CMD_RUN  = 2'b01;
    localparam logic [1:0]       CMD_HALT = 2'b10;
    localparam logic [1:0]       CMD_STEP = 2'b11;
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0] ZERO     = CNT_W'(0);

    // A divisor of zero would never reach a boundary, so it is promoted to one.
    function automatic logic [CNT_W-1:0] map_div(input logic [CNT_W-1:0] d);
        map_div = (d == ZERO) ? ONE : d;
    endfunction

    state_t           state_r, state_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic [CNT_W-1:0] div_r, div_s;
    logic [CNT_W-1:0] pend_div_r, pend_div_s;
    logic             pend_r, pend_s;
    logic             ce_r, ce_s;
    logic             sd_r, sd_s;
    logic             cmd_rdy_r, cfg_rdy_r;
    logic             cmd_acc_s, cfg_acc_s, bnd_s;
    logic [CNT_W-1:0] cfg_val_s;

    // Next-state, counter and divisor bookkeeping for the run-control FSM.
    always_comb begin
        cmd_acc_s  = cmd_valid_i & cmd_rdy_r;
        cfg_acc_s  = cfg_valid_i & cfg_rdy_r;
        cfg_val_s  = map_div(cfg_div_i);
        bnd_s      = (cnt_r == (div_r - ONE));
        state_s    = state_r;
        cnt_s      = cnt_r;
        div_s      = div_r;
        pend_s     = pend_r;
        pend_div_s = pend_div_r;
        ce_s       = 1'b0;
        sd_s       = 1'b0;
        case (state_r)
            ST_HALT: begin
                cnt_s = ZERO;
                if (cfg_acc_s) begin
                    div_s = cfg_val_s;
                end else if (pend_r) begin
                    div_s  = pend_div_r;
                    pend_s = 1'b0;
                end else begin
                    div_s = div_r;
                end
                if (cmd_acc_s && (cmd_i == CMD_RUN)) begin
                    state_s = ST_RUN;
                end else if (cmd_acc_s && (cmd_i == CMD_STEP)) begin
                    state_s = ST_STEP;
                end else begin
                    state_s = ST_HALT;
                end
            end
            ST_RUN: begin
                if (cmd_acc_s && (cmd_i == CMD_HALT)) begin
                    // Halting cancels the current period; any pending divisor lands now.
                    state_s = ST_HALT;
                    cnt_s   = ZERO;
                    pend_s  = 1'b0;
                    if (cfg_acc_s) begin
                        div_s = cfg_val_s;
                    end else if (pend_r) begin
                        div_s = pend_div_r;
                    end else begin
                        div_s = div_r;
                    end
                end else if (bnd_s) begin
                    cnt_s  = ZERO;
                    ce_s   = 1'b1;
                    pend_s = cfg_acc_s;
                    if (pend_r) begin
                        div_s = pend_div_r;
                    end else begin
                        div_s = div_r;
                    end
                    if (cfg_acc_s) begin
                        pend_div_s = cfg_val_s;
                    end else begin
                        pend_div_s = pend_div_r;
                    end
                end else begin
                    cnt_s = cnt_r + ONE;
                    if (cfg_acc_s) begin
                        pend_s     = 1'b1;
                        pend_div_s = cfg_val_s;
                    end else begin
                        pend_s = pend_r;
                    end
                end
            end
            ST_STEP: begin
                if (bnd_s) begin
                    state_s = ST_HALT;
                    cnt_s   = ZERO;
                    ce_s    = 1'b1;
                    sd_s    = 1'b1;
                    pend_s  = 1'b0;
                    if (cfg_acc_s) begin
                        div_s = cfg_val_s;
                    end else if (pend_r) begin
                        div_s = pend_div_r;
                    end else begin
                        div_s = div_r;
                    end
                end else begin
                    cnt_s = cnt_r + ONE;
                    if (cfg_acc_s) begin
                        pend_s     = 1'b1;
                        pend_div_s = cfg_val_s;
                    end else begin
                        pend_s = pend_r;
                    end
                end
            end
            default: begin
                state_s = ST_HALT;
                cnt_s   = ZERO;
                pend_s  = 1'b0;
            end
        endcase
    end

    // State and registered outputs; ready flags are precomputed from next state.
    always_ff @(posedge clk_i or negedge x_reset) begin
        if (!x_reset) begin
            state_r    <= ST_HALT;
            cnt_r      <= ZERO;
            div_r      <= CNT_W'(DIV_RST);
            pend_div_r <= ZERO;
            pend_r     <= 1'b0;
            ce_r       <= 1'b0;
            sd_r       <= 1'b0;
            cmd_rdy_r  <= 1'b1;
            cfg_rdy_r  <= 1'b1;
        end else begin
            state_r    <= state_s;
            cnt_r      <= cnt_s;
            div_r      <= div_s;
            pend_div_r <= pend_div_s;
            pend_r     <= pend_s;
            ce_r       <= ce_s;
            sd_r       <= sd_s;
            cmd_rdy_r  <= (state_s != ST_STEP);
            cfg_rdy_r  <= ~pend_s;
        end
    end

    assign cmd_ready_o = cmd_rdy_r;
    assign cfg_ready_o = cfg_rdy_r;
    assign ce_o        = ce_r;
    assign step_done_o = sd_r;
    assign state_o     = state_r;
    assign div_o       = div_r;

endmodule

// File: tb/tb_riscv_clk_ctrl.sv
// Self-checking bench: directed scenarios with literal expectations plus randomized
// traffic compared every cycle against an edge-scheduled behavioural model.
module tb_riscv_clk_ctrl;

    localparam int CNT_W = 8;
    localparam int DIV_RST = 3;

    logic             clk_i = 1'b0;
    logic             x_reset = 1'b0;
    logic             cmd_valid_i = 1'b0;
    logic [1:0]       cmd_i = 2'b00;
    logic             cmd_ready_o;
    logic             cfg_valid_i = 1'b0;
    logic [CNT_W-1:0] cfg_div_i = '0;
    logic             cfg_ready_o;
    logic             ce_o;
    logic             step_done_o;
    logic [1:0]       state_o;
    logic [CNT_W-1:0] div_o;

    int errors = 0;
    int checks = 0;

    // Model: state 0 HALT / 1 RUN / 2 STEP; boundaries scheduled as absolute edge numbers.
    int m_state, m_div, m_pend, m_pend_div, m_next, m_edge;
    int m_ce, m_sd, m_cmd_rdy, m_cfg_rdy;

    riscv_clk_ctrl #(.CNT_W(CNT_W), .DIV_RST(DIV_RST)) dut (
        .clk_i(clk_i), .x_reset(x_reset),
        .cmd_valid_i(cmd_valid_i), .cmd_i(cmd_i), .cmd_ready_o(cmd_ready_o),
        .cfg_valid_i(cfg_valid_i), .cfg_div_i(cfg_div_i), .cfg_ready_o(cfg_ready_o),
        .ce_o(ce_o), .step_done_o(step_done_o), .state_o(state_o), .div_o(div_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_div = DIV_RST; m_pend = 0; m_pend_div = 0;
        m_next = 0; m_edge = 0; m_ce = 0; m_sd = 0; m_cmd_rdy = 1; m_cfg_rdy = 1;
    endtask

    task automatic model_step();
        int cmd_acc, cfg_acc, nd;
        m_edge++;
        cmd_acc = int'(cmd_valid_i) & m_cmd_rdy;
        cfg_acc = int'(cfg_valid_i) & m_cfg_rdy;
        nd = (cfg_div_i == 0) ? 1 : int'(cfg_div_i);
        m_ce = 0; m_sd = 0;
        if (m_state == 0) begin
            if (cfg_acc != 0) m_div = nd;
            if (cmd_acc != 0 && (cmd_i == 2'b01 || cmd_i == 2'b11)) begin
                m_state = (cmd_i == 2'b01) ? 1 : 2;
                m_next = m_edge + m_div;
            end
        end else if (m_state == 1 && cmd_acc != 0 && cmd_i == 2'b10) begin
            m_state = 0;
            if (cfg_acc != 0) m_div = nd;
            else if (m_pend != 0) m_div = m_pend_div;
            m_pend = 0;
        end else if (m_edge == m_next) begin
            m_ce = 1;
            if (m_state == 2) begin
                m_sd = 1; m_state = 0;
                if (cfg_acc != 0) m_div = nd;
                else if (m_pend != 0) m_div = m_pend_div;
                m_pend = 0;
            end else begin
                if (m_pend != 0) m_div = m_pend_div;
                m_pend = cfg_acc;
                m_pend_div = nd;
                m_next = m_edge + m_div;
            end
        end else if (cfg_acc != 0) begin
            m_pend = 1; m_pend_div = nd;
        end
        m_cmd_rdy = (m_state == 2) ? 0 : 1;
        m_cfg_rdy = (m_pend != 0) ? 0 : 1;
    endtask

    task automatic cyc();
        @(posedge clk_i);
        if (x_reset) model_step();
        @(negedge clk_i);
    endtask

    task automatic drive(input logic cv, input logic [1:0] c, input logic fv, input int d);
        cmd_valid_i = cv; cmd_i = c; cfg_valid_i = fv; cfg_div_i = CNT_W'(d);
    endtask

    task automatic idle();
        drive(1'b0, 2'b00, 1'b0, 0);
    endtask

    // Per-cycle comparison of every output against the model.
    initial begin
        forever begin
            @(negedge clk_i);
            chk("ce", int'(ce_o), m_ce);
            chk("step_done", int'(step_done_o), m_sd);
            chk("state", int'(state_o), m_state);
            chk("div", int'(div_o), m_div);
            chk("cmd_ready", int'(cmd_ready_o), m_cmd_rdy);
            chk("cfg_ready", int'(cfg_ready_o), m_cfg_rdy);
        end
    end

    initial begin
        model_reset();
        repeat (2) @(negedge clk_i);
        chk("rst_ce", int'(ce_o), 0);
        chk("rst_state", int'(state_o), 0);
        chk("rst_div", int'(div_o), 3);
        chk("rst_cmd_rdy", int'(cmd_ready_o), 1);
        chk("rst_cfg_rdy", int'(cfg_ready_o), 1);
        x_reset = 1'b1;
        cyc();

        // RUN with the reset divisor: pulses on every third cycle.
        drive(1'b1, 2'b01, 1'b0, 0); cyc(); idle();
        for (int k = 1; k <= 9; k++) begin
            cyc();
            chk("t1_ce", int'(ce_o), (k % 3 == 0) ? 1 : 0);
            chk("t1_state", int'(state_o), 1);
        end

        // STEP with a divisor written on the same edge.
        drive(1'b1, 2'b10, 1'b0, 0); cyc();
        drive(1'b1, 2'b11, 1'b1, 5); cyc(); idle();
        chk("t2_div", int'(div_o), 5);
        chk("t2_cmd_rdy", int'(cmd_ready_o), 0);
        chk("t2_state", int'(state_o), 2);
        for (int k = 1; k <= 5; k++) begin
            cyc();
            chk("t2_ce", int'(ce_o), (k == 5) ? 1 : 0);
            chk("t2_sd", int'(step_done_o), (k == 5) ? 1 : 0);
        end
        chk("t2_state_end", int'(state_o), 0);
        chk("t2_cmd_rdy_end", int'(cmd_ready_o), 1);

        // Divisor change while running waits for the next boundary.
        drive(1'b1, 2'b01, 1'b1, 4); cyc(); idle();
        for (int k = 1; k <= 4; k++) cyc();
        chk("t3_ce4", int'(ce_o), 1);
        drive(1'b0, 2'b00, 1'b1, 2); cyc(); idle();
        chk("t3_cfg_rdy_lo", int'(cfg_ready_o), 0);
        cyc(); chk("t3_ce6", int'(ce_o), 0);
        cyc(); chk("t3_ce7", int'(ce_o), 0);
        cyc(); chk("t3_ce8", int'(ce_o), 1);
        chk("t3_cfg_rdy_hi", int'(cfg_ready_o), 1);
        chk("t3_div", int'(div_o), 2);
        cyc(); chk("t3_ce9", int'(ce_o), 0);
        cyc(); chk("t3_ce10", int'(ce_o), 1);
        drive(1'b1, 2'b10, 1'b0, 0); cyc(); idle();

        // HALT on a boundary edge suppresses the pulse; RUN restarts the period.
        drive(1'b1, 2'b01, 1'b1, 3); cyc(); idle();
        cyc(); cyc();
        drive(1'b1, 2'b10, 1'b0, 0); cyc(); idle();
        chk("t4_ce", int'(ce_o), 0);
        chk("t4_state", int'(state_o), 0);
        drive(1'b1, 2'b01, 1'b0, 0); cyc(); idle();
        for (int k = 1; k <= 3; k++) begin
            cyc();
            chk("t4_restart_ce", int'(ce_o), (k == 3) ? 1 : 0);
        end
        drive(1'b1, 2'b10, 1'b0, 0); cyc(); idle();

        // Divisor zero maps to one: enable every cycle.
        drive(1'b0, 2'b00, 1'b1, 0); cyc(); idle();
        chk("t5_div", int'(div_o), 1);
        drive(1'b1, 2'b01, 1'b0, 0); cyc(); idle();
        for (int k = 1; k <= 3; k++) begin
            cyc();
            chk("t5_ce", int'(ce_o), 1);
        end
        drive(1'b1, 2'b10, 1'b0, 0); cyc(); idle();

        // Asynchronous reset during STEP with a pending divisor.
        drive(1'b1, 2'b11, 1'b1, 7); cyc(); idle();
        drive(1'b0, 2'b00, 1'b1, 9); cyc(); idle();
        chk("t6_pending", int'(cfg_ready_o), 0);
        #2 x_reset = 1'b0;
        model_reset();
        #1;
        chk("t6_ce", int'(ce_o), 0);
        chk("t6_sd", int'(step_done_o), 0);
        chk("t6_state", int'(state_o), 0);
        chk("t6_div", int'(div_o), 3);
        chk("t6_cmd_rdy", int'(cmd_ready_o), 1);
        chk("t6_cfg_rdy", int'(cfg_ready_o), 1);
        @(negedge clk_i);
        x_reset = 1'b1;

        // Randomized traffic against the model, with occasional asynchronous resets.
        for (int i = 0; i < 4000; i++) begin
            drive(1'($urandom_range(0, 3) == 0), 2'($urandom_range(0, 3)),
                  1'($urandom_range(0, 5) == 0), int'($urandom_range(0, 6)));
            if ($urandom_range(0, 399) == 0) begin
                #2 x_reset = 1'b0;
                model_reset();
                @(posedge clk_i);
                @(negedge clk_i);
                x_reset = 1'b1;
            end else begin
                cyc();
            end
        end
        idle();
        cyc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
